packet_buffer_reader: RTL and testbench

PACKET_BUFFER_READER -- requirements
Module: packet_buffer_reader

---
 rtl/packet_buffer_reader_pkg.sv | 31 +++
 rtl/packet_buffer_reader_fifo.sv | 80 ++++++++
 rtl/packet_buffer_reader.sv | 166 ++++++++++++++++
 tb/tb_packet_buffer_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_buffer_reader_pkg.sv
// ============================================================================
// Module      : packet_buffer_reader_pkg
// Description : Shared packet-buffer parameters, clog2 helper and reader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package packet_buffer_reader_pkg;

  localparam int BYTE_LEN                   = 8;
  localparam int PACKET_BUFFER_SIZE         = 2048;
  localparam int PACKET_BUFFER_READ_LATENCY = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/packet_buffer_reader_fifo.sv
// ============================================================================
// Module      : byte_stream_fifo
// Description : Small register FIFO holding returned bytes for the reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_stream_fifo
  import packet_buffer_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [clog2(DEPTH+1)-1:0]  count
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_buffer_reader.sv
// ============================================================================
// Module      : packet_buffer_reader
// Description : Streams a packet out of the buffer RAM as a byte stream.
//               Optional PACKET_BUFFER_READER_STATS_EN adds a packet_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_buffer_reader
  import packet_buffer_reader_pkg::*;
#(
  parameter int RAM_SIZE     = PACKET_BUFFER_SIZE,
  parameter int READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [clog2(RAM_SIZE)-1:0] start_addr,
  input  logic [clog2(RAM_SIZE):0]   len,
  output logic                       read_req,
  output logic [clog2(RAM_SIZE)-1:0] read_addr,
  input  logic                       read_ready,
  input  logic [BYTE_LEN-1:0]        read_out,
  output logic                       out_valid,
  output logic [BYTE_LEN-1:0]        out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
`ifdef PACKET_BUFFER_READER_STATS_EN
  ,
  output logic [15:0]                packet_count
`endif
);

  localparam int AW     = clog2(RAM_SIZE);
  localparam int LW     = AW + 1;
  localparam int CW     = clog2(FIFO_DEPTH + 1);
  localparam int HOLD_W = clog2(READ_LATENCY + 2);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LW-1:0]     req_left_q, req_left_d;
  logic [LW-1:0]     out_left_q, out_left_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;
  logic              done_q, done_d;

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_fifo_count;
  logic              w_pop;
  logic              w_ret;
  logic              w_req;
  logic [CW:0]       w_occupancy;

  assign out_valid = !w_empty;
  assign out_last  = out_valid && (out_left_q == LW'(1));
  assign w_pop     = out_valid && out_ready;
  // Returns right after reset belong to requests from before it and are dropped.
  assign w_ret     = read_ready && (inflight_q != '0) && (holdoff_q == '0);

  assign w_occupancy = (CW+1)'(inflight_q) + (CW+1)'(w_fifo_count) - (CW+1)'(w_pop);
  assign w_req       = (state_q == ST_FETCH) && (req_left_q != '0) && !w_full
                       && (w_occupancy < (CW+1)'(FIFO_DEPTH));

  assign read_req  = w_req;
  assign read_addr = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  byte_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_LEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_ret),
    .push_data (read_out),
    .pop       (w_pop),
    .pop_data  (out_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    holdoff_d  = (holdoff_q != '0) ? holdoff_q - HOLD_W'(1) : '0;
    inflight_d = inflight_q + CW'(w_req) - CW'(w_ret);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            addr_d     = start_addr;
            req_left_d = len;
            out_left_d = len;
          end
        end
      end
      ST_FETCH: begin
        if (w_req) begin
          addr_d     = (addr_q == AW'(RAM_SIZE - 1)) ? '0 : addr_q + AW'(1);
          req_left_d = req_left_q - LW'(1);
          if (req_left_q == LW'(1)) state_d = ST_DRAIN;
        end
      end
      default: ;
    endcase

    if (w_pop) out_left_d = out_left_q - LW'(1);
    if (w_pop && out_last) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      out_left_q <= '0;
      inflight_q <= '0;
      holdoff_q  <= HOLD_W'(READ_LATENCY);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      out_left_q <= out_left_d;
      inflight_q <= inflight_d;
      holdoff_q  <= holdoff_d;
      done_q     <= done_d;
    end
  end

`ifdef PACKET_BUFFER_READER_STATS_EN
  logic [15:0] packet_count_q, packet_count_d;

  always_comb begin
    packet_count_d = done_d ? packet_count_q + 16'd1 : packet_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) packet_count_q <= '0;
    else        packet_count_q <= packet_count_d;
  end

  assign packet_count = packet_count_q;
`else
  // Statistics counter is not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_packet_buffer_reader.sv
// ============================================================================
// Module      : tb_packet_buffer_reader
// Description : Directed self-checking bench with a latency-2 buffer RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_buffer_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] start_addr = '0;
  logic [11:0] len = '0;
  logic        read_req;
  logic [10:0] read_addr;
  logic        read_ready;
  logic [7:0]  read_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef PACKET_BUFFER_READER_STATS_EN
  logic [15:0] packet_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  packet_buffer_reader #(
    .RAM_SIZE     (2048),
    .READ_LATENCY (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .read_req   (read_req),
    .read_addr  (read_addr),
    .read_ready (read_ready),
    .read_out   (read_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
`ifdef PACKET_BUFFER_READER_STATS_EN
    ,
    .packet_count (packet_count)
`endif
  );

  function automatic logic [7:0] ram_byte(input logic [10:0] a);
    return a[7:0] ^ {5'b0, a[10:8]} ^ 8'h5A;
  endfunction

  // Buffer RAM driver model: two-stage pipeline, not reset, so stale returns can cross reset.
  logic        st0_v = 1'b0, st1_v = 1'b0;
  logic [10:0] st0_a = '0, st1_a = '0;
  always @(posedge clk) begin
    st0_v <= read_req;
    st0_a <= read_addr;
    st1_v <= st0_v;
    st1_a <= st0_a;
  end
  assign read_ready = st1_v;
  assign read_out   = ram_byte(st1_a);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pkt(input logic [10:0] a, input logic [11:0] n);
    start      = 1'b1;
    start_addr = a;
    len        = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic collect(input logic [10:0] base, input int n);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 200) begin
      if (out_valid && out_ready) begin
        chk(out_data, ram_byte(base + 11'(idx)), "byte_data");
        chk(out_last, (idx == n - 1), "byte_last");
        idx++;
      end
      tick();
      guard++;
    end
    chk(idx, n, "byte_count");
    chk(done, 1, "done_after_last");
    chk(busy, 0, "busy_after_last");
  endtask

  initial begin
    int nreq;
    int hs;
    int g;
    logic seen;

    repeat (3) @(negedge clk);
    chk({read_req, out_valid, out_last, busy, done}, 0, "reset_ctrl");
    chk({read_addr, out_data}, 0, "reset_data");
    reset = 1'b1;
    tick();

    // Basic packet: exact cycle timing
    out_ready = 1'b1;
    start_pkt(11'h010, 12'd4);
    for (int c = 1; c <= 8; c++) begin
      chk(read_req, (c <= 4), "t1_read_req");
      if (c <= 4) chk(read_addr, 11'h010 + 11'(c - 1), "t1_read_addr");
      chk(out_valid, (c >= 4 && c <= 7), "t1_out_valid");
      if (c >= 4 && c <= 7) begin
        chk(out_data, ram_byte(11'h010 + 11'(c - 4)), "t1_out_data");
        chk(out_last, (c == 7), "t1_out_last");
      end
      chk(done, (c == 8), "t1_done");
      chk(busy, (c <= 7), "t1_busy");
      tick();
    end
    chk(done, 0, "t1_done_one_cycle");

    // Address wrap
    start_pkt(11'h7FE, 12'd4);
    chk(read_addr, 11'h7FE, "t2_addr0");
    tick();
    chk(read_addr, 11'h7FF, "t2_addr1");
    tick();
    chk(read_addr, 11'h000, "t2_addr2");
    chk(read_req, 1, "t2_req2");
    tick();
    chk(read_addr, 11'h001, "t2_addr3");
    collect(11'h7FE, 4);
    tick();

    // Backpressure: requests stop at FIFO depth, no loss
    out_ready = 1'b0;
    start_pkt(11'h020, 12'd16);
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      if (read_req) nreq++;
      if (c == 6) start = 1'b1;
      else        start = 1'b0;
      start_addr = 11'h300;
      len        = 12'd3;
      tick();
    end
    start = 1'b0;
    chk(nreq, 4, "t3_req_cap");
    chk(read_req, 0, "t3_req_stalled");
    chk(out_valid, 1, "t3_valid_stalled");
    chk(out_data, ram_byte(11'h020), "t3_data_stalled");
    tick();
    chk(out_data, ram_byte(11'h020), "t3_data_stable");
    chk(out_last, 0, "t3_last_stalled");
    out_ready = 1'b1;
    collect(11'h020, 16);
    tick();

    // Zero-length packet
    start_pkt(11'h055, 12'd0);
    chk(done, 1, "t4_done");
    chk(read_req, 0, "t4_no_req");
    chk(busy, 0, "t4_not_busy");
    tick();
    chk(done, 0, "t4_done_pulse");
    chk(read_req, 0, "t4_no_req_later");

    // Reset in the middle of a packet
    start_pkt(11'h200, 12'd10);
    hs = 0;
    g  = 0;
    while (hs < 4 && g < 50) begin
      if (out_valid && out_ready) hs++;
      tick();
      g++;
    end
    chk(out_data, ram_byte(11'h204), "t5_fifth_byte");
    reset = 1'b0;
    #1;
    chk({read_req, out_valid, out_last, busy, done}, 0, "t5_reset_ctrl");
    chk({read_addr, out_data}, 0, "t5_reset_data");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | out_valid | busy;
      tick();
    end
    chk(seen, 0, "t5_stale_discard");
    start_pkt(11'h100, 12'd2);
    collect(11'h100, 2);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | out_valid;
      tick();
    end
    chk(seen, 0, "t5_no_extra_bytes");

`ifdef PACKET_BUFFER_READER_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    start_pkt(11'h400, 12'd3);
    collect(11'h400, 3);
    tick();
    start_pkt(11'h000, 12'd0);
    tick();
    start_pkt(11'h500, 12'd5);
    collect(11'h500, 5);
    tick();
    chk(packet_count, 16'd3, "t6_packet_count");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
